// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw button pads in, debounced levels, strobes and press count out
interface button_debouncer_if #(parameter int NUM_BTN = 4, parameter int CNT_W = 8);
  logic [NUM_BTN-1:0] btn_in, btn_level, btn_press, btn_release;
  logic [CNT_W-1:0] press_count;
  modport master(output btn_in, input btn_level, btn_press, btn_release, press_count);
  modport slave(input btn_in, output btn_level, btn_press, btn_release, press_count);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes bouncy pads, accepts levels stable for DEBOUNCE_CYCLES, emits press/release strobes and a press count
module button_debouncer #(
  parameter int NUM_BTN = 4,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int CNT_W = 8,
  parameter int ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst,
  button_debouncer_if.slave bus
);
  localparam int TW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(DEBOUNCE_CYCLES - 1);
  logic [NUM_BTN-1:0] s1, s2, level, press, rel, done;
  logic [NUM_BTN-1:0][TW-1:0] timer;
  logic [CNT_W-1:0] count, pop;
  // done marks the edge on which a channel's mismatch run reaches full length
  always_comb begin
    done = '0;
    pop = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      done[k] = s2[k] != level[k] && timer[k] == LAST;
      pop = pop + CNT_W'(done[k] & s2[k]);
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      level <= '0;
      press <= '0;
      rel <= '0;
      timer <= '0;
      count <= '0;
    end else begin
      s1 <= ACTIVE_LOW != 0 ? ~bus.btn_in : bus.btn_in;
      s2 <= s1;
      level <= level ^ done;
      press <= done & s2;
      rel <= done & ~s2;
      count <= count + pop;
      for (int k = 0; k < NUM_BTN; k++)
        timer[k] <= (s2[k] == level[k] || done[k]) ? '0 : timer[k] + 1'b1;
    end
  assign bus.btn_level = level;
  assign bus.btn_press = press;
  assign bus.btn_release = rel;
  assign bus.press_count = count;
endmodule
